// File: rtl/encoder_8to3_seq.sv
// ============================================================================
// Module      : encoder_8to3_seq
// Description : Sequential 8-to-3 priority encoder. It emits one beat per
//               set bit of an accepted request word, in priority order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module encoder_8to3_seq #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] D,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] Y,
    output logic       last,
    output logic       none
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic       none_q, none_d;

    logic [2:0] sel_idx;
    logic       single_bit;

    // Later loop iterations override earlier ones, so loop direction sets priority.
    generate
        if (MSB_FIRST) begin : g_msb_first
            always_comb begin
                sel_idx = 3'd0;
                for (int i = 0; i < 8; i++) begin
                    if (pending_q[i]) begin
                        sel_idx = 3'(i);
                    end
                end
            end
        end else begin : g_lsb_first
            always_comb begin
                sel_idx = 3'd0;
                for (int i = 7; i >= 0; i--) begin
                    if (pending_q[i]) begin
                        sel_idx = 3'(i);
                    end
                end
            end
        end
    endgenerate

    assign single_bit = (pending_q != 8'h00) &&
                        ((pending_q & (pending_q - 8'd1)) == 8'h00);

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == EMIT);
        Y         = 3'd0;
        last      = 1'b0;
        none      = 1'b0;
        if (state_q == EMIT) begin
            Y    = sel_idx;
            last = none_q | single_bit;
            none = none_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        none_d    = none_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pending_d = D;
                    none_d    = (D == 8'h00);
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pending_d[sel_idx] = 1'b0;
                    if (last) begin
                        pending_d = 8'h00;
                        none_d    = 1'b0;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 8'h00;
            none_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            none_q    <= none_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_encoder_8to3_seq.sv
// ============================================================================
// Module      : tb_encoder_8to3_seq
// Description : Self-checking bench; MSB-first and LSB-first instances share
//               stimulus and are compared against a queue-based beat model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_encoder_8to3_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] d;
    logic       out_ready;

    logic       m_in_ready, m_out_valid, m_last, m_none;
    logic [2:0] m_y;
    logic       l_in_ready, l_out_valid, l_last, l_none;
    logic [2:0] l_y;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] y;
        logic       last;
        logic       none;
    } beat_t;

    typedef struct {
        logic [7:0]      d;
        int              n;
        logic            none;
        logic [7:0][2:0] y_msb;
        logic [7:0][2:0] y_lsb;
    } vec_t;

    beat_t qm[$];
    beat_t ql[$];
    bit    mdl_idle;

    encoder_8to3_seq #(.MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .D(d),
        .out_valid(m_out_valid), .out_ready(out_ready), .Y(m_y), .last(m_last), .none(m_none)
    );

    encoder_8to3_seq #(.MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready), .D(d),
        .out_valid(l_out_valid), .out_ready(out_ready), .Y(l_y), .last(l_last), .none(l_none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected beat lists are built directly from the set bits of the word.
    task automatic mdl_load(input logic [7:0] w);
        int n;
        int k;
        qm.delete();
        ql.delete();
        n = $countones(w);
        if (w == 8'h00) begin
            qm.push_back('{y: 3'd0, last: 1'b1, none: 1'b1});
            ql.push_back('{y: 3'd0, last: 1'b1, none: 1'b1});
        end else begin
            k = 0;
            for (int i = 7; i >= 0; i--) begin
                if (w[i]) begin
                    k++;
                    qm.push_back('{y: 3'(i), last: (k == n), none: 1'b0});
                end
            end
            k = 0;
            for (int i = 0; i < 8; i++) begin
                if (w[i]) begin
                    k++;
                    ql.push_back('{y: 3'(i), last: (k == n), none: 1'b0});
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("msb.in_ready",  32'(m_in_ready),  32'(mdl_idle));
        chk("msb.out_valid", 32'(m_out_valid), 32'(!mdl_idle));
        chk("msb.Y",    32'(m_y),    mdl_idle ? 32'd0 : 32'(qm[0].y));
        chk("msb.last", 32'(m_last), mdl_idle ? 32'd0 : 32'(qm[0].last));
        chk("msb.none", 32'(m_none), mdl_idle ? 32'd0 : 32'(qm[0].none));
        chk("lsb.in_ready",  32'(l_in_ready),  32'(mdl_idle));
        chk("lsb.out_valid", 32'(l_out_valid), 32'(!mdl_idle));
        chk("lsb.Y",    32'(l_y),    mdl_idle ? 32'd0 : 32'(ql[0].y));
        chk("lsb.last", 32'(l_last), mdl_idle ? 32'd0 : 32'(ql[0].last));
        chk("lsb.none", 32'(l_none), mdl_idle ? 32'd0 : 32'(ql[0].none));
    endtask

    // Called just after a negedge with inputs set: check, advance model, clock.
    task automatic cycle();
        compare_all();
        if (mdl_idle && in_valid) begin
            mdl_load(d);
            mdl_idle = 1'b0;
        end else if (!mdl_idle && out_ready) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
            if (qm.size() == 0) mdl_idle = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic mdl_reset();
        qm.delete();
        ql.delete();
        mdl_idle = 1'b1;
    endtask

    vec_t       vecs[6];
    logic [2:0] seen[$];

    initial begin
        vecs[0] = '{d: 8'hA4, n: 3, none: 1'b0,
                    y_msb: {15'd0, 3'd2, 3'd5, 3'd7}, y_lsb: {15'd0, 3'd7, 3'd5, 3'd2}};
        vecs[1] = '{d: 8'h00, n: 1, none: 1'b1, y_msb: 24'd0, y_lsb: 24'd0};
        vecs[2] = '{d: 8'h80, n: 1, none: 1'b0,
                    y_msb: {21'd0, 3'd7}, y_lsb: {21'd0, 3'd7}};
        vecs[3] = '{d: 8'h01, n: 1, none: 1'b0, y_msb: 24'd0, y_lsb: 24'd0};
        vecs[4] = '{d: 8'h0F, n: 4, none: 1'b0,
                    y_msb: {12'd0, 3'd0, 3'd1, 3'd2, 3'd3}, y_lsb: {12'd0, 3'd3, 3'd2, 3'd1, 3'd0}};
        vecs[5] = '{d: 8'h81, n: 2, none: 1'b0,
                    y_msb: {18'd0, 3'd0, 3'd7}, y_lsb: {18'd0, 3'd7, 3'd0}};

        rst       = 1'b1;
        in_valid  = 1'b0;
        d         = 8'h00;
        out_ready = 1'b0;
        mdl_reset();

        // Reset outputs must hold before any clock edge has occurred.
        #2;
        compare_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven words, back to back, sink always ready.
        out_ready = 1'b1;
        foreach (vecs[v]) begin
            in_valid = 1'b1;
            d        = vecs[v].d;
            chk("tbl.in_ready_before", 32'(m_in_ready), 32'd1);
            cycle();
            in_valid = 1'b0;
            d        = 8'h5A;
            for (int k = 0; k < vecs[v].n; k++) begin
                chk("tbl.msb.Y", 32'(m_y), 32'(vecs[v].y_msb[k]));
                chk("tbl.lsb.Y", 32'(l_y), 32'(vecs[v].y_lsb[k]));
                chk("tbl.last",  32'(m_last), 32'(k == vecs[v].n - 1));
                chk("tbl.none",  32'(m_none), 32'(vecs[v].none));
                cycle();
            end
            chk("tbl.in_ready_after", 32'(m_in_ready), 32'd1);
        end

        // 8'hFF with a stalling sink: indices held during stalls, each emitted once.
        in_valid = 1'b1;
        d        = 8'hFF;
        cycle();
        in_valid = 1'b0;
        seen.delete();
        for (int i = 0; i < 40 && !mdl_idle; i++) begin
            out_ready = ((i % 4) == 0) || ((i % 4) == 3);
            if (m_out_valid && out_ready) seen.push_back(m_y);
            cycle();
        end
        chk("ff.beats", 32'(seen.size()), 32'd8);
        for (int i = 0; i < 8 && i < seen.size(); i++) begin
            chk("ff.order", 32'(seen[i]), 32'(7 - i));
        end
        chk("ff.idle", 32'(m_in_ready), 32'd1);

        // Asynchronous reset after two of four beats of 8'h0F.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        d         = 8'h0F;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("rst.pre_valid", 32'(m_out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        mdl_reset();
        compare_all();
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        compare_all();
        in_valid = 1'b0;
        rst      = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        // First edge after release with in_valid accepts a new word.
        in_valid = 1'b1;
        d        = 8'h40;
        cycle();
        in_valid = 1'b0;
        chk("rst.new_word_y", 32'(m_y), 32'd6);
        cycle();

        // in_valid held with changing D during emission.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d = (i == 0) ? 8'h92 : 8'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            d         = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
